// File: rtl/mem_arb_pkg.sv
// Shared types for the memory round-robin arbiter.
// State encoding and index-width helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ISSUE = ST_ISSUE_ENC,
    ST_WAIT  = ST_WAIT_ENC
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_arbiter.sv
// Rotating-priority pick: first valid requester at or above ptr,
// wrapping around; one-hot grant plus binary index.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int              c;
  logic [IDX_W-1:0] ci;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    ci  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IDX_W'(c);
      if (!any && req[ci]) begin
        any     = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one single-port memory.
// Optional watchdog abort enabled by MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_wr_en,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  input  logic                          mem_ready,
  output logic                          busy
);

  localparam int IDX_W = idx_w(NUM_REQ);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt, gnt_q, rsp_valid_q;
  logic [IDX_W-1:0]     gnt_idx, rr_ptr;
  logic                 any;
  logic                 wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic                 accept, done, tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (any)
  );

  assign accept = (state_q == ST_IDLE) && any;
  assign done   = (state_q == ST_WAIT) && mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo = (state_q == ST_WAIT) && !mem_ready &&
               (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter clears in ISSUE so it measures WAIT cycles only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
      if (state_q == ST_ISSUE)
        cnt_q <= '0;
      else if (state_q == ST_WAIT)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign rsp_err = err_q;
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mem_ready || tmo) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE):  req_ready = gnt;
      (state_q == ST_ISSUE): begin
        mem_wr_en = wr_q;
        mem_rd_en = !wr_q;
        busy      = 1'b1;
      end
      (state_q == ST_WAIT):  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q       <= '0;
      rr_ptr      <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        gnt_q   <= gnt;
        wr_q    <= req_write[gnt_idx];
        addr_q  <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        rr_ptr  <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0
                 : gnt_idx + 1'b1;
      end
      if (done || tmo) rsp_valid_q <= gnt_q;
      if (done && !wr_q) rdata_q <= mem_rd_data;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter with a latency-programmable
// memory model; timeout case built only with MEM_ARB_TIMEOUT_EN.
module tb_mem_rr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wr_data, mem_rd_data;
  logic            rsp_err, mem_wr_en, mem_rd_en, mem_ready, busy;
  logic [AW-1:0]   mem_addr;

  mem_rr_arbiter #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  vld;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_err = 0;
  int            mem_lat = 1;
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_valid", 64'(rsp_valid), 64'(mon_e.vld));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  // Memory model: completion mem_lat cycles after the strobe.
  initial begin : mem_model
    logic [AW-1:0] a;
    logic [DW-1:0] rd;
    forever begin
      @(negedge clk);
      if (rst_n && (mem_rd_en || mem_wr_en)) begin
        a  = mem_addr;
        rd = mem_arr[a];
        if (mem_wr_en) begin
          mem_arr[a] = mem_wr_data;
          rd = ~mem_wr_data;
        end
        if (mem_lat >= 0) begin
          repeat (mem_lat) @(posedge clk);
          #1;
          mem_ready   = 1'b1;
          mem_rd_data = rd;
          @(posedge clk);
          #1;
          mem_ready   = 1'b0;
          mem_rd_data = '0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic accept(input int idx, input logic wr,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic err);
    exp_t e;
    int   k;
    req_write[idx] = wr;
    req_addr[idx*AW +: AW] = a;
    req_wdata[idx*DW +: DW] = d;
    req_valid[idx] = 1'b1;
    k = 0;
    #1;
    while (!req_ready[idx] && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    check("req_ready_onehot", 64'(req_ready), 64'(N'(1) << idx));
    e.vld = N'(1) << idx;
    if (!wr && !err) last_rd = mem_arr[a];
    e.rdata = last_rd;
    e.err   = err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain", 64'(sb.size() != 0 || busy), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int   got;
    int   k;
    logic seen;
    logic fin;
    exp_t e;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    mem_ready   = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < (1 << AW); i++)
      mem_arr[i] = 32'hA500_0000 | DW'(i);
    mem_arr[5] = 32'hDEAD_BEEF;
    do_reset();

    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_strobes", 64'({mem_wr_en, mem_rd_en}), 64'd0);

    // Single read from requester 2, exact cycle timing.
    mem_lat = 2;
    accept(2, 1'b0, AW'(5), '0, 1'b0);
    check("t1_rd_en", 64'(mem_rd_en), 64'd1);
    check("t1_wr_en", 64'(mem_wr_en), 64'd0);
    check("t1_addr", 64'(mem_addr), 64'h5);
    @(posedge clk); #1;
    check("t1_strobe_off", 64'(mem_rd_en), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("t1_no_early_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("t1_rsp_valid", 64'(rsp_valid), 64'b0100);
    check("t1_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    wait_done();

    // All requesters held valid: strict rotation from 0.
    do_reset();
    last_rd = '0;
    mem_lat = 1;
    for (int i = 0; i < N; i++) begin
      req_write[i] = 1'b0;
      req_addr[i*AW +: AW] = AW'(i * 16);
    end
    req_valid = '1;
    got = 0;
    k   = 0;
    #1;
    while (got < 5 && k < 100) begin
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), 64'(N'(1) << (got % N)));
        e.vld   = N'(1) << (got % N);
        last_rd = mem_arr[(got % N) * 16];
        e.rdata = last_rd;
        e.err   = 1'b0;
        sb.push_back(e);
        got++;
      end
      @(posedge clk);
      #2;
      k++;
    end
    req_valid = '0;
    check("rr_grant_count", 64'(got), 64'd5);
    wait_done();

    // Long write: address/data stable, stray valid ignored.
    mem_lat = 6;
    accept(1, 1'b1, AW'(10'h3FF), 32'h1234_5678, 1'b0);
    check("t3_wr_en", 64'(mem_wr_en), 64'd1);
    seen = 1'b0;
    fin  = 1'b0;
    for (int i = 0; i < 20 && !fin; i++) begin
      @(posedge clk);
      #2;
      req_valid[3] = (i < 3);
      if (seen) begin
        check("t3_rsp_valid", 64'(rsp_valid), 64'b0010);
        check("t3_rsp_rdata", 64'(rsp_rdata), 64'(last_rd));
        fin = 1'b1;
      end else begin
        check("t3_addr_hold", 64'(mem_addr), 64'h3FF);
        check("t3_data_hold", 64'(mem_wr_data), 64'h1234_5678);
        check("t3_no_ready", 64'(req_ready), 64'd0);
        seen = mem_ready;
      end
    end
    req_valid[3] = 1'b0;
    check("t3_completed", 64'(fin), 64'd1);
    wait_done();
    check("t3_mem_written", 64'(mem_arr[10'h3FF]), 64'h1234_5678);

    // Stray completion while idle.
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("stray_ready_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during WAIT drops the command and rewinds rr_ptr.
    mem_lat = 4;
    accept(0, 1'b0, AW'(7), '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    last_rd = '0;
    check("t4_req_ready", 64'(req_ready), 64'd0);
    check("t4_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_strobes", 64'({mem_wr_en, mem_rd_en}), 64'd0);
    check("t4_mem_addr", 64'(mem_addr), 64'd0);
    check("t4_mem_wr_data", 64'(mem_wr_data), 64'd0);
    check("t4_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("t4_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t4_idle_after", 64'(busy), 64'd0);
    req_valid = '1;
    #1;
    check("t4_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    mem_lat = 1;
    accept(0, 1'b0, AW'(8), '0, 1'b0);
    wait_done();

`ifdef MEM_ARB_TIMEOUT_EN
    // No completion: abort with error after TMO wait cycles.
    mem_lat = -1;
    accept(2, 1'b0, AW'(9), '0, 1'b1);
    k = 0;
    while (rsp_valid == '0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("tmo_latency", 64'(k), 64'(TMO + 1));
    mem_lat = 1;
    accept(3, 1'b0, AW'(11), '0, 1'b0);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter and sequencer that shares one single-port memory (wr_en/rd_en/addr/wr_data request, rd_data/ready completion) among NUM_REQ requesters. It accepts one command at a time through a valid/ready handshake, issues it to the memory as a one-cycle strobe, waits for the memory's completion pulse, and returns a per-requester response. It sits between client engines and the shared memory.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, memory data width
- ADDR_WIDTH, 10, memory address width
- TIMEOUT_CYCLES, 255, watchdog limit (used only with MEM_ARB_TIMEOUT_EN)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_ready  out  NUM_REQ  one-hot accept, combinational in IDLE
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid of a read
- rsp_err  out  1  one-cycle pulse with rsp_valid on timeout abort
- mem_wr_en, mem_rd_en  out  1  one-cycle command strobes
- mem_addr  out  ADDR_WIDTH  held from ISSUE until completion
- mem_wr_data  out  DATA_WIDTH  held from ISSUE until completion
- mem_rd_data  in  DATA_WIDTH  memory read data
- mem_ready  in  1  memory completion pulse
- busy  out  1  high in ISSUE and WAIT

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: grant = first i with req_valid[i], searching from rr_ptr upward with wrap; req_ready[grant]=1 same cycle; on the edge latch grant, write, addr, wdata; rr_ptr <= (grant+1) mod NUM_REQ; go ISSUE. No valid: stay, req_ready=0.
- ISSUE: exactly one of mem_wr_en/mem_rd_en high for one cycle; go WAIT.
- WAIT: mem_addr/mem_wr_data held; on mem_ready, capture mem_rd_data into rsp_rdata (reads only), pulse rsp_valid[grant] next cycle, go IDLE.
- rsp_rdata holds the last read value across writes and idle.
- mem_ready outside WAIT ignored.
- req_valid dropped before acceptance: no effect, no state change.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem strobes 0, mem_addr 0, mem_wr_data 0, busy 0.
- Reset mid-transaction: in-flight command dropped, no response issued.

## Timing
- Cycle 0 handshake, cycle 1 strobe, mem_ready sampled from cycle 2; rsp_valid one cycle after mem_ready. Minimum accept-to-response: 3 cycles.
- rsp_valid cycle is IDLE: a new handshake may occur in the same cycle.
- Throughput: at most one command per 3 cycles.

## Configuration
- MEM_ARB_TIMEOUT_EN defined: counter starts at ISSUE; if mem_ready not seen after TIMEOUT_CYCLES cycles in WAIT, abort to IDLE, pulse rsp_valid[grant] and rsp_err, rsp_rdata unchanged.
- Undefined: no counter, WAIT indefinitely, rsp_err tied 0.

## Structure
- Package mem_arb_pkg: state enum typedef, encoding constants, clog2-based index width helper.
- Sub-module rr_arbiter: combinational rotating-priority pick from req_valid and rr_ptr, outputs one-hot grant and index.

## Test plan
- Single read, requester 2, addr 0x05, memory returns 0xDEADBEEF with mem_ready at cycle 3 -> mem_rd_en at cycle 1, rsp_valid=0b0100 and rsp_rdata=0xDEADBEEF at cycle 4.
- All four req_valid held high -> grants in order 0,1,2,3,0; no requester granted twice before others.
- Write from requester 1, addr 0x3FF, data 0x12345678, mem_ready delayed 5 cycles -> mem_addr/mem_wr_data stable throughout WAIT, rsp_valid[1] one cycle after mem_ready, rsp_rdata unchanged.
- rst_n asserted during WAIT, then mem_ready pulses -> all outputs at reset values, no rsp_valid, rr_ptr 0.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never -> rsp_valid and rsp_err pulse after timeout, next request accepted normally.
